// File: rtl/flappy_pkg.sv
// Shared constants and types for the Flappy VGA game: screen geometry,
// default bird geometry and physics, the game-phase encoding and a
// saturating add helper for 10-bit coordinates/speeds.
package flappy_pkg;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    ST_INITIAL = 2'd0,
    ST_FLIGHT  = 2'd1,
    ST_STOP    = 2'd2
  } flight_state_e;

  localparam int SCREEN_W        = 640;
  localparam int SCREEN_H        = 480;
  localparam int GROUND_Y_DEF    = 440;

  localparam int BIRD_X_DEF      = 200;
  localparam int BIRD_Y0_DEF     = 240;
  localparam int BIRD_W_DEF      = 20;
  localparam int BIRD_H_DEF      = 20;

  localparam int GRAVITY_DEF     = 1;
  localparam int FLAP_SPEED_DEF  = 10;
  localparam int MAX_FALL_DEF    = 12;
  localparam int TICK_CYCLES_DEF = 833334;

  // a + b clamped to lim, computed without 10-bit wrap
  function automatic coord_t sat_add(coord_t a, coord_t b, coord_t lim);
    logic [10:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[9:0];
  endfunction

endpackage

// File: rtl/flight_tick_gen.sv
// Physics tick generator: counts enabled cycles 0..TICK_CYCLES-1 and
// raises tick for the single cycle in which the count sits at its last
// value, then wraps. clr holds the count at zero.
module flight_tick_gen
  import flappy_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_CYCLES_DEF
) (
  input  logic clk_sys,
  input  logic rst_b,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // cycle counter, wrapping on the terminal count
  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/flight_physics.sv
// Bird vertical physics and game-phase FSM for Flappy VGA.
// Optional build macro CEILING_KILL_EN: when defined, touching the
// ceiling ends the flight (STOP); otherwise the bird is only clamped.
//
// state      | meaning
// -----------+--------------------------------------------------
// S_INITIAL  | bird parked at BIRD_Y0, waiting for Start
// S_FLIGHT   | physics running: gravity on ticks, flaps on press
// S_STOP     | bird on the ground (or ceiling kill), wait for Ack
module flight_physics
  import flappy_pkg::*;
#(
  parameter int BIRD_X      = BIRD_X_DEF,
  parameter int BIRD_Y0     = BIRD_Y0_DEF,
  parameter int BIRD_W      = BIRD_W_DEF,
  parameter int BIRD_H      = BIRD_H_DEF,
  parameter int GROUND_Y    = GROUND_Y_DEF,
  parameter int GRAVITY     = GRAVITY_DEF,
  parameter int FLAP_SPEED  = FLAP_SPEED_DEF,
  parameter int MAX_FALL    = MAX_FALL_DEF,
  parameter int TICK_CYCLES = TICK_CYCLES_DEF
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       Start,
  input  logic       Ack,
  input  logic       BtnPress,
  output logic [9:0] Bird_X_L,
  output logic [9:0] Bird_X_R,
  output logic [9:0] Bird_Y_T,
  output logic [9:0] Bird_Y_B,
  output logic [9:0] PositiveSpeed,
  output logic [9:0] NegativeSpeed,
  output logic       q_Initial,
  output logic       q_Flight,
  output logic       q_Stop
);

  localparam logic [1:0] S_INITIAL = ST_INITIAL;
  localparam logic [1:0] S_FLIGHT  = ST_FLIGHT;
  localparam logic [1:0] S_STOP    = ST_STOP;

  localparam coord_t Y0     = coord_t'(BIRD_Y0);
  localparam coord_t Y_LAND = coord_t'(GROUND_Y - BIRD_H);
  localparam coord_t GRAV   = coord_t'(GRAVITY);
  localparam coord_t FLAP   = coord_t'(FLAP_SPEED);
  localparam coord_t MAXF   = coord_t'(MAX_FALL);

  logic [1:0]  state, state_nxt;
  coord_t      y_t, y_t_nxt;
  coord_t      pos_spd, pos_spd_nxt;
  coord_t      neg_spd, neg_spd_nxt;
  logic        btn_prev;
  logic        btn_rise;
  logic        tick;
  logic        in_flight;
  logic [10:0] ground_sum;

  assign in_flight  = (state == S_FLIGHT);
  assign btn_rise   = BtnPress & ~btn_prev;
  assign ground_sum = {1'b0, y_t} + {1'b0, pos_spd} + 11'(BIRD_H);

  flight_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk_sys(Clk),
    .rst_b  (reset),
    .en     (in_flight),
    .clr    (~in_flight),
    .tick   (tick)
  );

  // next-state, position and speed; a flap wins over a same-cycle tick
  always_comb begin
    state_nxt   = state;
    y_t_nxt     = y_t;
    pos_spd_nxt = pos_spd;
    neg_spd_nxt = neg_spd;
    case (state)
      S_INITIAL: begin
        y_t_nxt     = Y0;
        pos_spd_nxt = '0;
        neg_spd_nxt = '0;
        if (Start) state_nxt = S_FLIGHT;
      end
      S_FLIGHT: begin
        if (btn_rise) begin
          pos_spd_nxt = '0;
          neg_spd_nxt = FLAP;
        end else if (tick) begin
          if (ground_sum >= 11'(GROUND_Y)) begin
            y_t_nxt     = Y_LAND;
            pos_spd_nxt = '0;
            neg_spd_nxt = '0;
            state_nxt   = S_STOP;
          end else if (neg_spd > y_t) begin
            y_t_nxt     = '0;
            neg_spd_nxt = '0;
`ifdef CEILING_KILL_EN
            pos_spd_nxt = '0;
            state_nxt   = S_STOP;
`endif
          end else begin
            y_t_nxt = y_t + pos_spd - neg_spd;
            if (neg_spd != '0) begin
              neg_spd_nxt = neg_spd - ((neg_spd < GRAV) ? neg_spd : GRAV);
            end else begin
              pos_spd_nxt = sat_add(pos_spd, GRAV, MAXF);
            end
          end
        end
      end
      S_STOP: begin
        if (Ack) begin
          state_nxt   = S_INITIAL;
          y_t_nxt     = Y0;
          pos_spd_nxt = '0;
          neg_spd_nxt = '0;
        end
      end
      default: begin
        state_nxt   = S_INITIAL;
        y_t_nxt     = Y0;
        pos_spd_nxt = '0;
        neg_spd_nxt = '0;
      end
    endcase
  end

  // state, physics registers and button history
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state    <= S_INITIAL;
      y_t      <= Y0;
      pos_spd  <= '0;
      neg_spd  <= '0;
      btn_prev <= 1'b0;
    end else begin
      state    <= state_nxt;
      y_t      <= y_t_nxt;
      pos_spd  <= pos_spd_nxt;
      neg_spd  <= neg_spd_nxt;
      btn_prev <= BtnPress;
    end
  end

  // bounding box and state flags for the renderer and game control
  always_comb begin
    Bird_X_L      = coord_t'(BIRD_X);
    Bird_X_R      = coord_t'(BIRD_X + BIRD_W);
    Bird_Y_T      = y_t;
    Bird_Y_B      = y_t + coord_t'(BIRD_H);
    PositiveSpeed = pos_spd;
    NegativeSpeed = neg_spd;
    q_Initial     = (state == S_INITIAL);
    q_Flight      = (state == S_FLIGHT);
    q_Stop        = (state == S_STOP);
  end

endmodule

// File: tb/tb_flight_physics.sv
// Scoreboard bench for flight_physics with a signed-velocity reference model.
module tb_flight_physics;

  localparam int T       = 4;
  localparam int X_L     = 200;
  localparam int X_R     = 220;
  localparam int Y0      = 240;
  localparam int H       = 20;
  localparam int GROUND  = 440;
  localparam int G       = 1;
  localparam int FLAP    = 10;
  localparam int MAXF    = 12;

  logic       Clk = 1'b0;
  logic       reset, Start, Ack, BtnPress;
  logic [9:0] Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B;
  logic [9:0] PositiveSpeed, NegativeSpeed;
  logic       q_Initial, q_Flight, q_Stop;

  flight_physics #(.TICK_CYCLES(T)) dut (
    .Clk          (Clk),
    .reset        (reset),
    .Start        (Start),
    .Ack          (Ack),
    .BtnPress     (BtnPress),
    .Bird_X_L     (Bird_X_L),
    .Bird_X_R     (Bird_X_R),
    .Bird_Y_T     (Bird_Y_T),
    .Bird_Y_B     (Bird_Y_B),
    .PositiveSpeed(PositiveSpeed),
    .NegativeSpeed(NegativeSpeed),
    .q_Initial    (q_Initial),
    .q_Flight     (q_Flight),
    .q_Stop       (q_Stop)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int y;
    int ps;
    int ns;
    int st;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model: phase 0/1/2, position, signed velocity (down positive)
  int m_st, m_y, m_v, m_cyc;
  bit m_prev;
  int n_ceiling = 0, n_ground = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int flags_of(int st);
    return (st == 0) ? 4 : (st == 1) ? 2 : 1;
  endfunction

  function automatic void model_step(bit rst_n_i, bit s, bit a, bit b);
    bit is_tick;
    int down, up;
    if (!rst_n_i) begin
      m_st = 0; m_y = Y0; m_v = 0; m_cyc = 0; m_prev = 0;
      return;
    end
    case (m_st)
      0: if (s) begin m_st = 1; m_cyc = 0; end
      1: begin
        is_tick = (m_cyc % T) == (T - 1);
        m_cyc++;
        if (b && !m_prev) begin
          m_v = -FLAP;
        end else if (is_tick) begin
          down = (m_v > 0) ? m_v : 0;
          up   = (m_v < 0) ? -m_v : 0;
          if (m_y + down + H >= GROUND) begin
            m_y = GROUND - H; m_v = 0; m_st = 2; n_ground++;
          end else if (up > m_y) begin
            m_y = 0; m_v = 0; n_ceiling++;
`ifdef CEILING_KILL_EN
            m_st = 2;
`endif
          end else begin
            m_y = m_y + m_v;
            if (m_v < 0) m_v = (m_v + G > 0) ? 0 : m_v + G;
            else         m_v = (m_v + G > MAXF) ? MAXF : m_v + G;
          end
        end
      end
      default: if (a) begin m_st = 0; m_y = Y0; m_v = 0; end
    endcase
    m_prev = b;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.y  = m_y;
    e.ps = (m_v > 0) ? m_v : 0;
    e.ns = (m_v < 0) ? -m_v : 0;
    e.st = m_st;
    sb_q.push_back(e);
  endfunction

  task automatic cyc(bit r, bit s, bit a, bit b);
    @(negedge Clk);
    reset = r; Start = s; Ack = a; BtnPress = b;
    model_step(r, s, a, b);
    push_exp();
  endtask

  // monitor: compare DUT outputs after every active edge against the queue
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("bird_y_t", Bird_Y_T, e.y);
        chk("bird_y_b", Bird_Y_B, e.y + H);
        chk("pos_speed", PositiveSpeed, e.ps);
        chk("neg_speed", NegativeSpeed, e.ns);
        chk("state_flags", {q_Initial, q_Flight, q_Stop}, flags_of(e.st));
        chk("bird_x_l", Bird_X_L, X_L);
        chk("bird_x_r", Bird_X_R, X_R);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit b;
    reset = 1'b0; Start = 1'b0; Ack = 1'b0; BtnPress = 1'b0;
    b = 1'b0;
    repeat (3) cyc(0, 0, 0, 0);

    // INITIAL ignores button and Ack, then Start
    cyc(1, 0, 0, 1);
    cyc(1, 0, 1, 1);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);

    // free fall to the ground with Start pulses that must be ignored
    for (int i = 0; i < 400 && m_st != 2; i++) cyc(1, (i % 7) == 0, 0, 0);

    // STOP ignores button and Start, then Ack
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, (i % 2) == 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 0);

    // flap: held button flaps once, release and re-press flaps again
    cyc(1, 1, 0, 0);
    repeat (10) cyc(1, 0, 0, 0);
    repeat (12) cyc(1, 0, 0, 1);
    repeat (3)  cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    repeat (12) cyc(1, 0, 0, 0);

    // climb into the ceiling with frequent flaps
    for (int i = 0; i < 260; i++) cyc(1, 0, 0, (i % 5) == 0);

    // then drop to the ground and acknowledge
    for (int i = 0; i < 400 && m_st != 2; i++) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);

    // randomized play
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) b = ~b;
      cyc(1, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, b);
    end

    // get airborne, then drop reset asynchronously mid-cycle
    cyc(1, 0, 1, 0);
    cyc(1, 1, 0, 0);
    repeat (6) cyc(1, 0, 0, 0);
    @(negedge Clk);
    #2;
    reset = 1'b0; Start = 1'b0; Ack = 1'b0; BtnPress = 1'b0;
    #1;
    chk("async_rst_y_t", Bird_Y_T, Y0);
    chk("async_rst_y_b", Bird_Y_B, Y0 + H);
    chk("async_rst_pos", PositiveSpeed, 0);
    chk("async_rst_neg", NegativeSpeed, 0);
    chk("async_rst_flags", {q_Initial, q_Flight, q_Stop}, 4);
    model_step(0, 0, 0, 0);
    push_exp();
    cyc(0, 0, 0, 0);

    // Start and Ack together in INITIAL go to FLIGHT
    cyc(1, 1, 1, 0);
    repeat (9) cyc(1, 0, 0, 0);

    @(posedge Clk);
    #3;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("model events: ceiling contacts %0d, ground landings %0d", n_ceiling, n_ground);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flight_physics.md
Name: flight_physics

Overview:
- Vertical flight physics and game-phase FSM for the bird in the Flappy VGA game.
- Holds bird position and a split-magnitude vertical velocity, applies gravity and flap impulses on a periodic physics tick, and detects ground collision.
- Feeds the VGA renderer with bird bounding-box coordinates and the top-level game control with its state flags.

Parameters:
- BIRD_X, 200, fixed left x coordinate of bird (pixels)
- BIRD_Y0, 240, initial top y coordinate
- BIRD_W, 20, bird width
- BIRD_H, 20, bird height
- GROUND_Y, 440, y of ground line; bird bottom reaching it ends flight
- GRAVITY, 1, downward speed increment per tick
- FLAP_SPEED, 10, upward speed loaded on flap
- MAX_FALL, 12, saturation of PositiveSpeed
- TICK_CYCLES, 833334, clock cycles per physics tick (60 Hz at 50 MHz); must be >= 1

Ports:
- Clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Start  in  1  level; INITIAL -> FLIGHT
- Ack  in  1  level; STOP -> INITIAL
- BtnPress  in  1  flap button, level (synchronous to Clk)
- Bird_X_L  out  10  left x = BIRD_X
- Bird_X_R  out  10  right x = BIRD_X + BIRD_W
- Bird_Y_T  out  10  top y (registered)
- Bird_Y_B  out  10  bottom y = Bird_Y_T + BIRD_H
- PositiveSpeed  out  10  downward speed magnitude, pixels/tick
- NegativeSpeed  out  10  upward speed magnitude, pixels/tick
- q_Initial, q_Flight, q_Stop  out  1 each  one-hot state flags

Behaviour:
- Reset (reset==0, async):
  - state INITIAL; Bird_Y_T = BIRD_Y0; both speeds 0; tick counter 0; button edge register 0.
  - Outputs: Bird_X_L=200, Bird_X_R=220, Bird_Y_T=240, Bird_Y_B=260, q_Initial=1.
- Exactly one q_* flag is high at all times.
- INITIAL:
  - Position held at BIRD_Y0; speeds 0; tick counter 0.
  - Start==1 at a clock edge -> FLIGHT at that edge.
  - BtnPress and Ack ignored.
- FLIGHT:
  - Tick counter increments each cycle; tick = (counter == TICK_CYCLES-1), after which the counter wraps to 0.
  - Start is ignored.
- Flap:
  - Rising edge of BtnPress (BtnPress=1, previous sample 0) sets PositiveSpeed=0 and NegativeSpeed=FLAP_SPEED. Position is unchanged that cycle.
  - A held button flaps once only.
  - A flap takes precedence over a tick occurring in the same cycle; that tick's physics is skipped, but the counter still wraps.
- Tick, no flap. All computations use pre-edge values.
  - Position: Y_T_next = Y_T + PositiveSpeed - NegativeSpeed.
  - Speed: if NegativeSpeed > 0, NegativeSpeed -= min(GRAVITY, NegativeSpeed); else PositiveSpeed = min(PositiveSpeed + GRAVITY, MAX_FALL).
- Ceiling: if NegativeSpeed > Y_T, then Y_T=0 and NegativeSpeed=0; the bird remains in FLIGHT.
- Ground:
  - Triggered if Y_T + PositiveSpeed + BIRD_H >= GROUND_Y on a tick.
  - Effects: Y_T = GROUND_Y - BIRD_H (420), both speeds 0, state -> STOP.
- STOP:
  - Position and speeds frozen; BtnPress ignored.
  - Ack==1 -> INITIAL, which reloads BIRD_Y0 and clears speeds.
- Arithmetic is unsigned 10-bit with an 11-bit intermediate for the ground compare; no wrap is permitted.
- Asserting reset mid-flight returns to the reset values immediately.

Optional Feature:
- Macro CEILING_KILL_EN.
- Defined: ceiling contact (NegativeSpeed > Y_T on a tick) clamps Y_T=0, zeroes speeds and enters STOP.
- Undefined: clamp only; the bird stays in FLIGHT.

Decomposition:
- Package flappy_pkg:
  - State encoding enum (INITIAL, FLIGHT, STOP).
  - Screen constants (640x480, GROUND_Y).
  - Default bird geometry.
  - 10-bit coordinate typedef.
- One natural sub-module: flight_tick_gen (parameterised TICK_CYCLES counter, enable and clear inputs, single-cycle tick output).
- Edge detect, FSM and physics stay in flight_physics.

Test Plan (TICK_CYCLES=4 unless stated):
- Reset -> Bird_Y_T=240, Bird_Y_B=260, Bird_X_L=200, Bird_X_R=220, speeds 0, q_Initial=1; Start pulse -> q_Flight=1 after that edge.
- Free fall: 1st tick Y_T=240, PositiveSpeed=1; 2nd tick Y_T=241, PositiveSpeed=2; PositiveSpeed saturates at 12.
- BtnPress rising edge -> PositiveSpeed=0, NegativeSpeed=10; next tick Y_T decreases by 10, NegativeSpeed=9; a held button produces no second flap; release then re-press flaps again.
- Ceiling: repeated flaps from Y_T=240 -> Y_T clamps to 0, NegativeSpeed=0, q_Flight stays 1 (q_Stop=1 with CEILING_KILL_EN).
- No flaps -> Y_T lands at exactly 420, Bird_Y_B=440, q_Stop=1, speeds 0; BtnPress ignored; Ack -> q_Initial=1, Y_T=240.
- Reset asserted mid-flight -> all outputs at reset values asynchronously; Start and Ack asserted together in INITIAL -> FLIGHT only.
